// File: rtl/ysyx_23060203_pkg.sv
// Shared constants and types for the IDU/EXU issue scoreboard.
// GPR geometry is also used by IDU and the register file.
package ysyx_23060203_pkg;

   localparam int SCB_MAX_INFLIGHT = 3;
   localparam int GPR_AW           = 5;
   localparam int GPR_NUM          = 32;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } scb_state_e;

endpackage

// File: rtl/ysyx_23060203_scb_cnt.sv
// Small up/down occupancy counter used for each GPR and for the in-flight total.
// Simultaneous inc and dec cancel out.
module ysyx_23060203_scb_cnt #(
   parameter int CW = 2
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          nz
);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (inc && !dec) begin
         cnt_reg <= cnt_reg + CW'(1);
      end else if (dec && !inc) begin
         cnt_reg <= cnt_reg - CW'(1);
      end
   end

   assign cnt = cnt_reg;
   assign nz  = |cnt_reg;

   // Wrap-around means the issue/writeback protocol was broken upstream.
   a_no_overflow : assert property (@(posedge clock) disable iff (reset)
      !(inc && !dec && (cnt_reg == {CW{1'b1}})));
   a_no_underflow : assert property (@(posedge clock) disable iff (reset)
      !(dec && !inc && (cnt_reg == '0)));

endmodule

// File: rtl/ysyx_23060203_scoreboard.sv
// Register-hazard and serialization scheduler between IDU and EXU/LSU.
// Counts pending writes per GPR plus total in-flight work and derives the IDU stall.
module ysyx_23060203_scoreboard
   import ysyx_23060203_pkg::*;
#(
   parameter int MAX_INFLIGHT = SCB_MAX_INFLIGHT,
   parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [GPR_AW-1:0]  chk_rs1,
   input  logic [GPR_AW-1:0]  chk_rs2,
   input  logic               chk_rs1_en,
   input  logic               chk_rs2_en,
   input  logic               chk_serial,
   output logic               stall,
   input  logic               iss_valid,
   input  logic [GPR_AW-1:0]  iss_rd,
   input  logic               iss_serial,
   input  logic               wb_valid,
   input  logic [GPR_AW-1:0]  wb_rd,
   output logic [CW-1:0]      inflight,
   output logic [GPR_NUM-1:0] busy,
   output logic               draining
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

   logic [CW-1:0]      pend_cnt [GPR_NUM];
   logic [GPR_NUM-1:0] pend_nz;
   logic               inflight_nz;
   logic [CW-1:0]      inflight_next;
   logic               raw1;
   logic               raw2;
   logic               full;
   logic               ser_wait;
   scb_state_e         state_reg;
   scb_state_e         state_next;

   // x0 is never tracked; its slot reads as permanently empty.
   assign pend_cnt[0] = '0;
   assign pend_nz[0]  = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < GPR_NUM; gi++) begin : g_pend
         ysyx_23060203_scb_cnt #(.CW(CW)) u_pend (
            .clock (clock),
            .reset (reset),
            .inc   (iss_valid && (iss_rd == GPR_AW'(gi))),
            .dec   (wb_valid && (wb_rd == GPR_AW'(gi))),
            .cnt   (pend_cnt[gi]),
            .nz    (pend_nz[gi])
         );
      end
   endgenerate

   ysyx_23060203_scb_cnt #(.CW(CW)) u_inflight (
      .clock (clock),
      .reset (reset),
      .inc   (iss_valid),
      .dec   (wb_valid),
      .cnt   (inflight),
      .nz    (inflight_nz)
   );

   assign inflight_next = inflight + CW'(iss_valid) - CW'(wb_valid);
   assign busy          = pend_nz;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         RUN:     if (iss_valid && iss_serial) state_next = DRAIN;
         DRAIN:   if (inflight_next == '0)     state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // No writeback bypass: a hazard only clears once the counter has decremented.
   always_comb begin
      raw1     = chk_rs1_en && (chk_rs1 != '0) && (pend_cnt[chk_rs1] != '0);
      raw2     = chk_rs2_en && (chk_rs2 != '0) && (pend_cnt[chk_rs2] != '0);
      full     = (inflight == MAX_CNT);
      ser_wait = chk_serial && inflight_nz;
      draining = (state_reg == DRAIN);
      stall    = raw1 || raw2 || full || ser_wait || draining;
   end

   a_no_issue_while_stall : assert property (@(posedge clock) disable iff (reset)
      !(iss_valid && stall));
   a_no_spurious_wb : assert property (@(posedge clock) disable iff (reset)
      !(wb_valid && !iss_valid && (inflight == '0)));

endmodule
